// File: rtl/alul_operand_sequencer.sv
// alul_operand_sequencer: byte-serial opcode/A/B front end that wraps the combinational 8-bit logic unit in a valid/ready transaction.
// Optional macro ALUL_CHAIN_EN: opcode bit 2 reuses the last result as operand A (accumulator chaining).
module alul_operand_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy,
    output logic [CNT_W-1:0] txn_count
);
    typedef enum logic [2:0] {GET_OP, GET_A, GET_B, EXEC, RESP} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b, r_res;
    logic [1:0]       r_sel;
    logic             r_valid, r_in_ready, r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic             w_in_xfer, w_res_xfer;
    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_res_xfer = r_valid && res_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= GET_OP;
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_sel      <= 2'b00;
            r_valid    <= 1'b0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                GET_OP: if (w_in_xfer) begin
                    r_sel  <= in_data[1:0];
                    r_busy <= 1'b1;
`ifdef ALUL_CHAIN_EN
                    if (in_data[2]) begin
                        r_a <= r_res;
                        if (in_data[1:0] == 2'b11) begin
                            r_b        <= '0;
                            r_in_ready <= 1'b0;
                            r_state    <= EXEC;
                        end else begin
                            r_state <= GET_B;
                        end
                    end else begin
                        r_state <= GET_A;
                    end
`else
                    r_state <= GET_A;
`endif
                end
                GET_A: if (w_in_xfer) begin
                    r_a <= in_data;
                    // NOT A has no B byte; B is zeroed so the unit sees a defined operand
                    if (r_sel == 2'b11) begin
                        r_b        <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= EXEC;
                    end else begin
                        r_state <= GET_B;
                    end
                end
                GET_B: if (w_in_xfer) begin
                    r_b        <= in_data;
                    r_in_ready <= 1'b0;
                    r_state    <= EXEC;
                end
                EXEC: begin
                    r_res   <= alu_out;
                    r_valid <= 1'b1;
                    r_state <= RESP;
                end
                RESP: if (w_res_xfer) begin
                    r_valid    <= 1'b0;
                    r_cnt      <= r_cnt + CNT_W'(1);
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= GET_OP;
                end
                default: begin
                    r_state    <= GET_OP;
                    r_valid    <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end
    assign in_ready  = r_in_ready;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_sel   = r_sel;
    assign res_valid = r_valid;
    assign res_data  = r_res;
    assign busy      = r_busy;
    assign txn_count = r_cnt;
endmodule
